// File: rtl/servo_ramp_ctrl_if.sv
// Command handshake carrying a requested servo duty and slew step into servo_ramp_ctrl.
interface servo_ramp_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_target;
  logic [WIDTH-1:0] cmd_step;

  modport master (
    output cmd_valid,
    output cmd_target,
    output cmd_step,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    input  cmd_step,
    output cmd_ready
  );
endinterface

// File: rtl/servo_ramp_ctrl.sv
// Rate-limited servo duty generator: slews d toward a clamped target by a fixed step,
// updating only on PWM frame boundaries so pwm_servos never sees a mid-period change.
module servo_ramp_ctrl #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned D_MIN  = 100,
  parameter int unsigned D_MAX  = 200,
  parameter int unsigned D_INIT = 150
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] t,
  servo_ramp_ctrl_if.slave cmd,
  output logic [WIDTH-1:0] d,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] DMIN_W  = WIDTH'(D_MIN);
  localparam logic [WIDTH-1:0] DMAX_W  = WIDTH'(D_MAX);
  localparam logic [WIDTH-1:0] DINIT_W = WIDTH'(D_INIT);
  localparam logic [WIDTH-1:0] T_FLOOR = WIDTH'(2);
  localparam logic [WIDTH:0]   ONE_X   = {{WIDTH{1'b0}}, 1'b1};

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RAMP = 1'b1;

  function automatic logic [WIDTH-1:0] clamp_duty(input logic [WIDTH-1:0] v);
    if (v < DMIN_W) return DMIN_W;
    if (v > DMAX_W) return DMAX_W;
    return v;
  endfunction

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] t_eff;
  logic [WIDTH:0]   cnt_inc, cnt_last;
  logic             frame_q, frame_d;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] stp_q, stp_d;
  logic             done_q, done_d;

  logic             accept;
  logic [WIDTH-1:0] tgt_new;
  logic             up;
  logic [WIDTH-1:0] diff;

  // Frame counter: the wrap is driven by the frame pulse itself, so a shrinking t
  // that leaves cnt beyond the new end still produces one frame and a clean wrap.
  always_comb begin
    t_eff    = (t < T_FLOOR) ? T_FLOOR : t;
    cnt_inc  = {1'b0, cnt_q} + ONE_X;
    cnt_last = {1'b0, t_eff} - ONE_X;
    cnt_d    = frame_q ? '0 : cnt_inc[WIDTH-1:0];
    frame_d  = ~frame_q & (cnt_inc >= cnt_last);
  end

  assign cmd.cmd_ready = (state_q == IDLE) & res;
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;
  assign tgt_new       = clamp_duty(cmd.cmd_target);

  // Differences are taken in the direction of motion so they never underflow.
  assign up   = (tgt_q > d_q);
  assign diff = up ? (tgt_q - d_q) : (d_q - tgt_q);

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    tgt_d   = tgt_q;
    stp_d   = stp_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d = tgt_new;
          stp_d = cmd.cmd_step;
          if (tgt_new == d_q) done_d = 1'b1;
          else                state_d = RAMP;
        end
      end
      RAMP: begin
        if (frame_q) begin
          if ((stp_q == '0) || (diff <= stp_q)) begin
            d_d     = tgt_q;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            d_d = up ? (d_q + stp_q) : (d_q - stp_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q <= IDLE;
      d_q     <= DINIT_W;
      cnt_q   <= '0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  // Target and step are only consulted after an accept, so they carry no reset.
  always_ff @(posedge clk) begin
    tgt_q <= tgt_d;
    stp_q <= stp_d;
  end

  assign d     = d_q;
  assign frame = frame_q;
  assign busy  = (state_q == RAMP);
  assign done  = done_q;

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Self-checking bench for servo_ramp_ctrl: directed scenarios plus randomized commands
// compared against a closed-form model of the clamped, frame-stepped ramp.
module tb_servo_ramp_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         res = 1'b0;
  logic [W-1:0] t   = 2000;
  logic [W-1:0] d;
  logic         frame, busy, done;

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int unsigned md     = 150;

  servo_ramp_ctrl_if #(.WIDTH(W)) cmd_if ();

  servo_ramp_ctrl #(.WIDTH(W), .D_MIN(100), .D_MAX(200), .D_INIT(150)) dut (
    .clk  (clk),
    .res  (res),
    .t    (t),
    .cmd  (cmd_if),
    .d    (d),
    .frame(frame),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned frame_bound();
    int unsigned te;
    te = (t < 2) ? 2 : t;
    return 2 * te + 4;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame(input int unsigned limit, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < limit && !ok; i++) begin
      if (frame === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    res = 1'b0;
    tick(2);
    res = 1'b1;
    md  = 150;
    tick(1);
  endtask

  // Issue one command at a negedge and follow it to completion, checking every frame step.
  task automatic run_ramp(input int unsigned target, input int unsigned step, input string name);
    int unsigned tg, n, delta, expv, prev;
    bit up, ok;
    tg = (target < 100) ? 100 : ((target > 200) ? 200 : target);
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready: got %b expected 1", name, cmd_if.cmd_ready);
    end
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = target;
    cmd_if.cmd_step   = step;
    @(negedge clk);
    cmd_if.cmd_valid  = 1'b0;
    if (tg == md) begin
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || d !== md) begin
        errors++; $display("FAIL %s noop: got done=%b busy=%b d=%0d expected done=1 busy=0 d=%0d", name, done, busy, d, md);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || d !== md) begin
        errors++; $display("FAIL %s noop_after: got done=%b busy=%b d=%0d expected done=0 busy=0 d=%0d", name, done, busy, d, md);
      end
    end else begin
      up    = tg > md;
      delta = up ? tg - md : md - tg;
      n     = (step == 0) ? 1 : (delta + step - 1) / step;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || cmd_if.cmd_ready !== 1'b0) begin
        errors++; $display("FAIL %s start: got busy=%b done=%b ready=%b expected busy=1 done=0 ready=0", name, busy, done, cmd_if.cmd_ready);
      end
      for (int unsigned k = 1; k <= n; k++) begin
        wait_frame(frame_bound(), ok);
        checks++;
        if (!ok) begin
          errors++; $display("FAIL %s frame_timeout: got no frame expected frame for step %0d", name, k);
          break;
        end
        prev = up ? md + (k - 1) * step : md - (k - 1) * step;
        checks++;
        if (d !== prev) begin
          errors++; $display("FAIL %s hold: got d=%0d expected %0d", name, d, prev);
        end
        @(negedge clk);
        expv = (k == n) ? tg : (up ? md + k * step : md - k * step);
        checks++;
        if (d !== expv) begin
          errors++; $display("FAIL %s step%0d: got d=%0d expected %0d", name, k, d, expv);
        end
        checks++;
        if (k == n) begin
          if (done !== 1'b1 || busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL %s finish: got done=%b busy=%b ready=%b expected 1 0 1", name, done, busy, cmd_if.cmd_ready);
          end
        end else if (done !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL %s midramp: got done=%b busy=%b expected 0 1", name, done, busy);
        end
      end
      md = tg;
    end
  endtask

  task automatic test_reset();
    bit ok;
    int c1;
    res = 1'b0;
    tick(5);
    checks++;
    if (d !== 150 || busy !== 1'b0 || done !== 1'b0 || cmd_if.cmd_ready !== 1'b0 || frame !== 1'b0) begin
      errors++; $display("FAIL reset_state: got d=%0d busy=%b done=%b ready=%b frame=%b expected 150 0 0 0 0", d, busy, done, cmd_if.cmd_ready, frame);
    end
    res = 1'b1;
    #1;
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 1", cmd_if.cmd_ready);
    end
    md = 150;
    @(negedge clk);
    wait_frame(frame_bound(), ok);
    c1 = cyc;
    tick(1);
    checks++;
    if (frame !== 1'b0) begin
      errors++; $display("FAIL frame_width: got %b expected 0", frame);
    end
    wait_frame(frame_bound(), ok);
    checks++;
    if (!ok || cyc - c1 != 2000) begin
      errors++; $display("FAIL frame_period: got %0d expected 2000", cyc - c1);
    end
  endtask

  task automatic test_ramp_up();
    run_ramp(200, 10, "ramp_up");
  endtask

  task automatic test_clamp_down();
    pulse_reset();
    run_ramp(50, 20, "clamp_down");
  endtask

  task automatic test_jump_noop();
    run_ramp(120, 0, "jump");
    run_ramp(120, 7, "noop_same");
  endtask

  task automatic test_busy_and_reset();
    bit ok;
    pulse_reset();
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_target = 200; cmd_if.cmd_step = 5;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    wait_frame(frame_bound(), ok);
    tick(1);
    checks++;
    if (d !== 155 || busy !== 1'b1) begin
      errors++; $display("FAIL busy_first_step: got d=%0d busy=%b expected 155 1", d, busy);
    end
    tick(3);
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_target = 100; cmd_if.cmd_step = 0;
    #1;
    checks++;
    if (cmd_if.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL busy_ready: got %b expected 0", cmd_if.cmd_ready);
    end
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    wait_frame(frame_bound(), ok);
    tick(1);
    checks++;
    if (d !== 160 || busy !== 1'b1) begin
      errors++; $display("FAIL busy_ignored_cmd: got d=%0d busy=%b expected 160 1", d, busy);
    end
    tick(10);
    res = 1'b0;
    tick(1);
    checks++;
    if (d !== 150 || busy !== 1'b0 || done !== 1'b0 || cmd_if.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL midramp_reset: got d=%0d busy=%b done=%b ready=%b expected 150 0 0 0", d, busy, done, cmd_if.cmd_ready);
    end
    res = 1'b1;
    md  = 150;
    tick(1);
    checks++;
    if (cmd_if.cmd_ready !== 1'b1 || d !== 150) begin
      errors++; $display("FAIL post_reset_idle: got ready=%b d=%0d expected 1 150", cmd_if.cmd_ready, d);
    end
  endtask

  task automatic test_period_change();
    bit ok;
    int c1;
    bit exp_f;
    wait_frame(frame_bound(), ok);
    tick(1201);
    t = 500;
    tick(1);
    checks++;
    if (frame !== 1'b1) begin
      errors++; $display("FAIL shrink_frame: got %b expected 1", frame);
    end
    c1 = cyc;
    tick(1);
    wait_frame(frame_bound(), ok);
    checks++;
    if (!ok || cyc - c1 != 500) begin
      errors++; $display("FAIL shrink_period: got %0d expected 500", cyc - c1);
    end
    tick(37);
    t = 1;
    wait_frame(frame_bound() + 600, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL t1_frame: got no frame expected frame");
    end
    exp_f = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      exp_f = ~exp_f;
      checks++;
      if (frame !== exp_f) begin
        errors++; $display("FAIL t1_pattern%0d: got %b expected %b", i, frame, exp_f);
      end
    end
  endtask

  task automatic test_random();
    int unsigned tg, st;
    t = 16;
    pulse_reset();
    for (int i = 0; i < 30; i++) begin
      tg = ($urandom_range(0, 4) == 0) ? md : $urandom_range(0, 300);
      st = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(5, 60);
      run_ramp(tg, st, $sformatf("rand%0d", i));
      tick($urandom_range(0, 3));
    end
  endtask

  initial begin
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_target = '0;
    cmd_if.cmd_step   = '0;
    test_reset();
    test_ramp_up();
    test_clamp_down();
    test_jump_noop();
    test_busy_and_reset();
    test_period_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
